// File: rtl/flappy_pkg.sv
// Shared types and default constants for the flappy physics blocks.
package flappy_pkg;

    typedef enum logic [1:0] {
        PHYS_IDLE    = 2'd0,
        PHYS_FLY     = 2'd1,
        PHYS_CRASHED = 2'd2
    } phys_state_t;

    localparam int FIELD_Y_W    = 4;
    localparam int TICK_DEFAULT = 20_000_000;

endpackage

// File: rtl/bird_motion_if.sv
// Bird motion bus: game-side controls in, sprite position/velocity and status out.
interface bird_motion_if
    import flappy_pkg::*;
#(
    parameter int Y_W = FIELD_Y_W,
    parameter int V_W = 4
);
    logic                  playing;
    logic                  flap;
    logic [Y_W-1:0]        bird_y;
    logic signed [V_W-1:0] velocity;
    logic                  tick;
    logic                  crashed;

    modport master (
        output playing, flap,
        input  bird_y, velocity, tick, crashed
    );

    modport slave (
        input  playing, flap,
        output bird_y, velocity, tick, crashed
    );
endinterface

// File: rtl/bird_motion_ctrl_tick.sv
// phys_tick_gen: free-running modulo-TICK_CYCLES counter that pulses on its last count.
// The counter holds when en is low, so a paused game resumes mid-interval.
module phys_tick_gen
    import flappy_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    assign tick = en && (count_reg == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= tick ? '0 : count_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/bird_motion_ctrl.sv
// Vertical motion engine for the bird sprite: gravity, flap impulse, terminal clamp, ground crash.
// Define BIRD_CEIL_KILL_EN to make a ceiling hit fatal as well.
module bird_motion_ctrl
    import flappy_pkg::*;
#(
    parameter int Y_W         = FIELD_Y_W,
    parameter int Y_START     = 8,
    parameter int TICK_CYCLES = TICK_DEFAULT,
    parameter int V_W         = 4,
    parameter int GRAVITY     = 1,
    parameter int FLAP_V      = -3,
    parameter int V_TERM      = 3
) (
    input logic          clk,
    input logic          reset,
    bird_motion_if.slave bus
);
    // Sum width covers both operands plus sign and carry headroom.
    localparam int S_W   = ((Y_W > V_W) ? Y_W : V_W) + 2;
    localparam int V_MIN = -(2 ** (V_W - 1));
    localparam int V_MAX = (2 ** (V_W - 1)) - 1;
    localparam logic signed [S_W-1:0] Y_FLOOR = S_W'((2 ** Y_W) - 1);

    if (FLAP_V < V_MIN || FLAP_V > V_MAX || V_TERM < V_MIN || V_TERM > V_MAX
        || TICK_CYCLES < 2) begin : g_param_check
        $error("bird_motion_ctrl: FLAP_V/V_TERM must fit in V_W and TICK_CYCLES must be >= 2");
    end

    phys_state_t           state_reg;
    logic [Y_W-1:0]        y_reg;
    logic signed [V_W-1:0] v_reg;
    logic                  tick_reg;
    logic                  crashed_reg;
    logic                  flap_pending_reg;

    logic                  tick_en;
    logic                  commit;
    logic signed [S_W-1:0] v_grav;
    logic signed [S_W-1:0] v_next;
    logic signed [S_W-1:0] y_sum;
    logic                  ceil_hit;
    logic                  floor_hit;

    assign tick_en = (state_reg == PHYS_FLY) && bus.playing;

    phys_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .clr   (1'b0),
        .tick  (commit)
    );

    always_comb begin
        v_grav = S_W'(v_reg) + S_W'(GRAVITY);
        if (flap_pending_reg || bus.flap) begin
            v_next = S_W'(FLAP_V);
        end else if (v_grav > S_W'(V_TERM)) begin
            v_next = S_W'(V_TERM);
        end else begin
            v_next = v_grav;
        end
        y_sum     = $signed(S_W'(y_reg)) + v_next;
        ceil_hit  = y_sum[S_W-1];
        floor_hit = !ceil_hit && (y_sum >= Y_FLOOR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= PHYS_IDLE;
            y_reg            <= Y_W'(Y_START);
            v_reg            <= '0;
            tick_reg         <= 1'b0;
            crashed_reg      <= 1'b0;
            flap_pending_reg <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            case (state_reg)
                PHYS_IDLE: begin
                    flap_pending_reg <= 1'b0;
                    if (bus.playing) state_reg <= PHYS_FLY;
                end
                PHYS_FLY: begin
                    if (!bus.playing) begin
                        state_reg        <= PHYS_IDLE;
                        flap_pending_reg <= 1'b0;
                    end else if (commit) begin
                        tick_reg         <= 1'b1;
                        flap_pending_reg <= 1'b0;
                        if (ceil_hit) begin
                            y_reg <= '0;
                            v_reg <= '0;
`ifdef BIRD_CEIL_KILL_EN
                            crashed_reg <= 1'b1;
                            state_reg   <= PHYS_CRASHED;
`endif
                        end else if (floor_hit) begin
                            y_reg       <= Y_FLOOR[Y_W-1:0];
                            v_reg       <= '0;
                            crashed_reg <= 1'b1;
                            state_reg   <= PHYS_CRASHED;
                        end else begin
                            y_reg <= y_sum[Y_W-1:0];
                            v_reg <= v_next[V_W-1:0];
                        end
                    end else if (bus.flap) begin
                        flap_pending_reg <= 1'b1;
                    end
                end
                default: begin
                    crashed_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.bird_y   = y_reg;
    assign bus.velocity = v_reg;
    assign bus.tick     = tick_reg;
    assign bus.crashed  = crashed_reg;
endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Bench for bird_motion_ctrl with TICK_CYCLES=4: directed scenarios plus randomized run vs a reference model.
module tb_bird_motion_ctrl;
    localparam int TICKS = 4;
    localparam int YMAX  = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference model state (plain integers, mode 0=idle 1=fly 2=crashed)
    int m_mode, m_cnt, m_y, m_v, m_pend, m_tick, m_crash;

    bird_motion_if #(.Y_W(4), .V_W(4)) bus ();

    bird_motion_ctrl #(.TICK_CYCLES(TICKS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit p, input bit f, input bit r);
        int nv, s;
        if (r) begin
            m_mode = 0; m_cnt = 0; m_y = 8; m_v = 0; m_pend = 0; m_tick = 0; m_crash = 0;
        end else begin
            m_tick = 0;
            if (m_mode == 0) begin
                m_pend = 0;
                if (p) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!p) begin
                    m_mode = 0; m_pend = 0;
                end else if (m_cnt == TICKS - 1) begin
                    m_cnt = 0; m_tick = 1;
                    nv = (m_pend != 0 || f) ? -3 : ((m_v + 1 > 3) ? 3 : m_v + 1);
                    s = m_y + nv;
                    m_pend = 0;
                    if (s < 0) begin
                        m_y = 0; m_v = 0;
`ifdef BIRD_CEIL_KILL_EN
                        m_crash = 1; m_mode = 2;
`endif
                    end else if (s >= YMAX) begin
                        m_y = YMAX; m_v = 0; m_crash = 1; m_mode = 2;
                    end else begin
                        m_y = s; m_v = nv;
                    end
                end else begin
                    m_cnt++;
                    if (f) m_pend = 1;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, sample 1 time unit later.
    task automatic cyc(input bit p, input bit f, input bit r);
        bus.playing = p;
        bus.flap    = f;
        reset       = r;
        @(posedge clk);
        model_step(p, f, r);
        #1;
    endtask

    task automatic test_reset();
        cyc(0, 0, 1);
        tests_run++;
        if (bus.bird_y !== 4'd8) begin tests_failed++; $display("FAIL reset_y: got %0d want 8", bus.bird_y); end
        tests_run++;
        if (bus.velocity !== 4'sd0) begin tests_failed++; $display("FAIL reset_v: got %0d want 0", bus.velocity); end
        tests_run++;
        if (bus.tick !== 1'b0 || bus.crashed !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags: tick=%b crashed=%b want 0 0", bus.tick, bus.crashed);
        end
        $display("[TB] reset: y=%0d v=%0d", bus.bird_y, bus.velocity);
    endtask

    task automatic test_freefall();
        int exp_y[4] = '{9, 11, 14, 15};
        int exp_v[4] = '{1, 2, 3, 0};
        int gap;
        cyc(0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            gap = 0;
            do begin cyc(1, 0, 0); gap++; end while (bus.tick !== 1'b1 && gap < 12);
            tests_run++;
            if (bus.tick !== 1'b1) begin
                tests_failed++; $display("FAIL freefall_timeout[%0d]: no tick in %0d cycles", k, gap);
            end
            tests_run++;
            if (k > 0 && gap != TICKS) begin
                tests_failed++; $display("FAIL freefall_gap[%0d]: got %0d want %0d", k, gap, TICKS);
            end
            tests_run++;
            if (bus.bird_y !== 4'(exp_y[k]) || bus.velocity !== 4'(exp_v[k])) begin
                tests_failed++;
                $display("FAIL freefall_yv[%0d]: got y=%0d v=%0d want y=%0d v=%0d", k, bus.bird_y, bus.velocity, exp_y[k], exp_v[k]);
            end
            $display("[TB] freefall tick %0d: y=%0d v=%0d crashed=%b", k, bus.bird_y, bus.velocity, bus.crashed);
        end
        tests_run++;
        if (bus.crashed !== 1'b1) begin tests_failed++; $display("FAIL ground_crash: got %b want 1", bus.crashed); end
    endtask

    task automatic test_crash_sticky();
        for (int i = 0; i < 16; i++) begin
            cyc(i[2], i[0], 0);
            tests_run++;
            if (bus.bird_y !== 4'd15 || bus.crashed !== 1'b1 || bus.tick !== 1'b0) begin
                tests_failed++;
                $display("FAIL crash_sticky[%0d]: got y=%0d crashed=%b tick=%b want 15 1 0", i, bus.bird_y, bus.crashed, bus.tick);
            end
        end
        $display("[TB] crash sticky: y=%0d crashed=%b", bus.bird_y, bus.crashed);
    endtask

    task automatic test_flap();
        int exp_y[3] = '{5, 3, 2};
        int exp_v[3] = '{-3, -2, -1};
        int n;
        cyc(0, 0, 1);
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin cyc(1, 0, 0); n++; end while (bus.tick !== 1'b1 && n < 12);
            tests_run++;
            if (bus.tick !== 1'b1 || bus.bird_y !== 4'(exp_y[k]) || bus.velocity !== 4'(exp_v[k])) begin
                tests_failed++;
                $display("FAIL flap[%0d]: got tick=%b y=%0d v=%0d want 1 %0d %0d", k, bus.tick, bus.bird_y, bus.velocity, exp_y[k], exp_v[k]);
            end
            $display("[TB] flap tick %0d: y=%0d v=%0d", k, bus.bird_y, bus.velocity);
        end
    endtask

    task automatic test_double_flap();
        cyc(0, 0, 1);
        cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        tests_run++;
        if (bus.tick !== 1'b1 || bus.bird_y !== 4'd5 || bus.velocity !== -4'sd3) begin
            tests_failed++;
            $display("FAIL double_flap: got tick=%b y=%0d v=%0d want 1 5 -3", bus.tick, bus.bird_y, bus.velocity);
        end
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0);
        tests_run++;
        if (bus.tick !== 1'b1 || bus.bird_y !== 4'd2 || bus.velocity !== -4'sd3) begin
            tests_failed++;
            $display("FAIL commit_flap: got tick=%b y=%0d v=%0d want 1 2 -3", bus.tick, bus.bird_y, bus.velocity);
        end
        $display("[TB] double flap / commit flap: y=%0d v=%0d", bus.bird_y, bus.velocity);
    endtask

    task automatic test_ceiling();
        logic exp_crash;
`ifdef BIRD_CEIL_KILL_EN
        exp_crash = 1'b1;
`else
        exp_crash = 1'b0;
`endif
        cyc(0, 0, 1);
        cyc(1, 1, 0);
        for (int i = 0; i < 3 * TICKS; i++) cyc(1, 1, 0);
        tests_run++;
        if (bus.tick !== 1'b1 || bus.bird_y !== 4'd0 || bus.velocity !== 4'sd0) begin
            tests_failed++;
            $display("FAIL ceiling_yv: got tick=%b y=%0d v=%0d want 1 0 0", bus.tick, bus.bird_y, bus.velocity);
        end
        tests_run++;
        if (bus.crashed !== exp_crash) begin
            tests_failed++; $display("FAIL ceiling_crash: got %b want %b", bus.crashed, exp_crash);
        end
        $display("[TB] ceiling: y=%0d v=%0d crashed=%b", bus.bird_y, bus.velocity, bus.crashed);
    endtask

    task automatic test_pause_and_reset();
        cyc(0, 0, 1);
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, i[1], 0);
            tests_run++;
            if (bus.tick !== 1'b0 || bus.bird_y !== 4'd8 || bus.velocity !== 4'sd0) begin
                tests_failed++;
                $display("FAIL pause[%0d]: got tick=%b y=%0d v=%0d want 0 8 0", i, bus.tick, bus.bird_y, bus.velocity);
            end
        end
        cyc(1, 0, 0); cyc(1, 0, 0);
        tests_run++;
        if (bus.tick !== 1'b0) begin tests_failed++; $display("FAIL resume_early: got tick=%b want 0", bus.tick); end
        cyc(1, 0, 0);
        tests_run++;
        if (bus.tick !== 1'b1 || bus.bird_y !== 4'd9) begin
            tests_failed++; $display("FAIL resume_tick: got tick=%b y=%0d want 1 9", bus.tick, bus.bird_y);
        end
        for (int i = 0; i < 6; i++) cyc(1, 0, 0);
        cyc(1, 0, 1);
        tests_run++;
        if (bus.bird_y !== 4'd8 || bus.velocity !== 4'sd0 || bus.tick !== 1'b0 || bus.crashed !== 1'b0) begin
            tests_failed++;
            $display("FAIL midfall_reset: got y=%0d v=%0d tick=%b crashed=%b want 8 0 0 0", bus.bird_y, bus.velocity, bus.tick, bus.crashed);
        end
        $display("[TB] pause/resume and mid-fall reset: y=%0d v=%0d", bus.bird_y, bus.velocity);
    endtask

    task automatic test_random();
        bit p, f, r;
        int errs = 0;
        cyc(0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            p = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 299) == 0);
            cyc(p, f, r);
            tests_run++;
            if ({bus.bird_y, bus.velocity, bus.tick, bus.crashed} !== {4'(m_y), 4'(m_v), 1'(m_tick), 1'(m_crash)}) begin
                tests_failed++; errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got y=%0d v=%0d tick=%b crashed=%b want y=%0d v=%0d tick=%0d crashed=%0d",
                             i, bus.bird_y, bus.velocity, bus.tick, bus.crashed, m_y, m_v, m_tick, m_crash);
            end
        end
        $display("[TB] random: 3000 cycles, %0d mismatching", errs);
    endtask

    initial begin
        bus.playing = 1'b0;
        bus.flap    = 1'b0;
        test_reset();
        test_freefall();
        test_crash_sticky();
        test_flap();
        test_double_flap();
        test_ceiling();
        test_pause_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
